ifu_dispatch_ctrl: RTL and testbench

- In-order dispatch scheduler between the 4-lane IFU fetch interface (lanes A-D) and the EXU.
- Accepts up to 4 instructions per cycle into a circular instruction buffer.
- Issues up to 2 per cycle, oldest first, to two EXU issue ports.
- Tags each instruction with a wrapping sequence number.

---
 rtl/ifu_dispatch_ctrl.sv | 154 +++++++++++++++
 tb/tb_ifu_dispatch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_dispatch_ctrl.sv
// In-order dispatch buffer: up to 4 fetched instructions in, up to 2 issued out per cycle.
// Optional perf counters are enabled by defining IFU_DISPATCH_PERF_EN.
module ifu_dispatch_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    ifu_instA_valid,
    input  logic                    ifu_instB_valid,
    input  logic                    ifu_instC_valid,
    input  logic                    ifu_instD_valid,
    output logic                    ifu_instA_allowIn,
    output logic                    ifu_instB_allowIn,
    output logic                    ifu_instC_allowIn,
    output logic                    ifu_instD_allowIn,
    input  logic [DATA_W-1:0]       ifu_instA_data,
    input  logic [DATA_W-1:0]       ifu_instB_data,
    input  logic [DATA_W-1:0]       ifu_instC_data,
    input  logic [DATA_W-1:0]       ifu_instD_data,
    output logic                    iss0_valid,
    input  logic                    iss0_ready,
    output logic [DATA_W-1:0]       iss0_data,
    output logic [SEQ_W-1:0]        iss0_seq,
    output logic                    iss1_valid,
    input  logic                    iss1_ready,
    output logic [DATA_W-1:0]       iss1_data,
    output logic [SEQ_W-1:0]        iss1_seq,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef IFU_DISPATCH_PERF_EN
    ,
    output logic [31:0]             perf_full_stall,
    output logic [31:0]             perf_dual_issue
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic [SEQ_W-1:0]  r_seq;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [SEQ_W-1:0]  r_tag  [DEPTH];

    logic [3:0]        w_valid;
    logic [DATA_W-1:0] w_ldata [4];
    logic [OCC_W-1:0]  w_free;
    logic [3:0]        w_allow;
    logic [3:0]        w_fire;
    logic [OCC_W-1:0]  w_enq_cnt;
    logic              w_iss0_fire;
    logic              w_iss1_fire;
    logic [OCC_W-1:0]  w_iss_cnt;
    logic [PTR_W-1:0]  w_head1;

    // Handshakes: a transfer happens on a cycle where valid && ready (allowIn on the
    // fetch side) are both high; allowIn depends only on registered occupancy and flush,
    // and a non-accepted lane must hold its valid/data until it is taken.
    always_comb begin
        w_valid    = {ifu_instD_valid, ifu_instC_valid, ifu_instB_valid, ifu_instA_valid};
        w_ldata[0] = ifu_instA_data;
        w_ldata[1] = ifu_instB_data;
        w_ldata[2] = ifu_instC_data;
        w_ldata[3] = ifu_instD_data;
        w_free     = OCC_W'(DEPTH) - r_occ;
        w_allow    = '0;
        w_fire     = '0;
        w_enq_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            w_allow[k] = (w_free > OCC_W'(k)) && !flush;
        end
        w_fire[0] = w_valid[0] && w_allow[0];
        for (int k = 1; k < 4; k++) begin
            w_fire[k] = w_fire[k-1] && w_valid[k] && w_allow[k];
        end
        for (int k = 0; k < 4; k++) begin
            w_enq_cnt = w_enq_cnt + OCC_W'(w_fire[k]);
        end
        // Port 1 only ever takes the second-oldest entry alongside port 0 (in-order).
        w_iss0_fire = iss0_valid && iss0_ready;
        w_iss1_fire = iss1_valid && iss1_ready && w_iss0_fire;
        w_iss_cnt   = OCC_W'(w_iss0_fire) + OCC_W'(w_iss1_fire);
        w_head1     = r_head + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_seq  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_iss_cnt);
            r_tail <= r_tail + PTR_W'(w_enq_cnt);
            r_occ  <= r_occ + w_enq_cnt - w_iss_cnt;
            r_seq  <= r_seq + SEQ_W'(w_enq_cnt);
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_fire[k]) begin
                r_data[r_tail + PTR_W'(k)] <= w_ldata[k];
                r_tag[r_tail + PTR_W'(k)]  <= r_seq + SEQ_W'(k);
            end
        end
    end

    assign ifu_instA_allowIn = w_allow[0];
    assign ifu_instB_allowIn = w_allow[1];
    assign ifu_instC_allowIn = w_allow[2];
    assign ifu_instD_allowIn = w_allow[3];

    assign iss0_valid = (r_occ != '0);
    assign iss1_valid = (r_occ >= OCC_W'(2));
    assign iss0_data  = r_data[r_head];
    assign iss0_seq   = r_tag[r_head];
    assign iss1_data  = r_data[w_head1];
    assign iss1_seq   = r_tag[w_head1];
    assign occupancy  = r_occ;

`ifdef IFU_DISPATCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_dual;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_dual  <= '0;
        end else begin
            if (ifu_instA_valid && !w_allow[0] && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_iss1_fire && (r_perf_dual != '1)) begin
                r_perf_dual <= r_perf_dual + 32'd1;
            end
        end
    end

    assign perf_full_stall = r_perf_stall;
    assign perf_dual_issue = r_perf_dual;
`endif

endmodule

// File: tb/tb_ifu_dispatch_ctrl.sv
// Directed bench for ifu_dispatch_ctrl: vector table, sequence-wrap run with a
// scoreboard queue, and mid-operation asynchronous reset.
module tb_ifu_dispatch_ctrl;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int SEQ_W  = 8;
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int NV     = 21;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              a_v, b_v, c_v, d_v;
    logic              a_al, b_al, c_al, d_al;
    logic [DATA_W-1:0] a_d, b_d, c_d, d_d;
    logic              iss0_valid, iss0_ready, iss1_valid, iss1_ready;
    logic [DATA_W-1:0] iss0_data, iss1_data;
    logic [SEQ_W-1:0]  iss0_seq, iss1_seq;
    logic [OCC_W-1:0]  occupancy;
`ifdef IFU_DISPATCH_PERF_EN
    logic [31:0]       perf_full_stall;
    logic [31:0]       perf_dual_issue;
`endif

    ifu_dispatch_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ifu_instA_valid(a_v), .ifu_instB_valid(b_v),
        .ifu_instC_valid(c_v), .ifu_instD_valid(d_v),
        .ifu_instA_allowIn(a_al), .ifu_instB_allowIn(b_al),
        .ifu_instC_allowIn(c_al), .ifu_instD_allowIn(d_al),
        .ifu_instA_data(a_d), .ifu_instB_data(b_d),
        .ifu_instC_data(c_d), .ifu_instD_data(d_d),
        .iss0_valid(iss0_valid), .iss0_ready(iss0_ready),
        .iss0_data(iss0_data), .iss0_seq(iss0_seq),
        .iss1_valid(iss1_valid), .iss1_ready(iss1_ready),
        .iss1_data(iss1_data), .iss1_seq(iss1_seq),
        .occupancy(occupancy)
`ifdef IFU_DISPATCH_PERF_EN
        ,
        .perf_full_stall(perf_full_stall),
        .perf_dual_issue(perf_dual_issue)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;   // bit0 = lane A
        logic [127:0] d;       // lane k at d[32k +: 32]
        logic         fl;
        logic [1:0]   rdy;     // bit0 = iss0_ready, bit1 = iss1_ready
        logic [3:0]   e_allow;
        logic         e_v0;
        logic [31:0]  e_d0;
        logic [7:0]   e_s0;
        logic         e_v1;
        logic [31:0]  e_d1;
        logic [7:0]   e_s1;
        logic [3:0]   e_occ;   // after the clock edge
    } vec_t;

    vec_t vecs [NV];
    int total;
    int bad;
    logic [SEQ_W+DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [127:0] d,
                         input logic fl, input logic [1:0] rdy);
        {d_v, c_v, b_v, a_v} = valid;
        a_d = d[31:0];
        b_d = d[63:32];
        c_d = d[95:64];
        d_d = d[127:96];
        flush = fl;
        iss0_ready = rdy[0];
        iss1_ready = rdy[1];
    endtask

    logic [SEQ_W+DATA_W-1:0] item;
    logic [SEQ_W-1:0] prev_seq;
    logic wrap_seen;
    logic [SEQ_W-1:0] model_seq;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        drive(4'b0000, 128'h0, 1'b0, 2'b00);

        //                valid    lanes D..A                                  fl    rdy    allow    v0 d0     s0   v1 d1     s1   occ
        vecs[0]  = '{4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 2'b00, 4'b1111, 0, 32'h0, 0,  0, 32'h0, 0,  4'd4};
        vecs[1]  = '{4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 2'b00, 4'b1111, 1, 32'h11, 0, 1, 32'h22, 1, 4'd8};
        vecs[2]  = '{4'b1111, {32'h58, 32'h57, 32'h56, 32'h55}, 1'b0, 2'b11, 4'b0000, 1, 32'h11, 0, 1, 32'h22, 1, 4'd6};
        vecs[3]  = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b0011, 1, 32'h33, 2, 1, 32'h44, 3, 4'd4};
        vecs[4]  = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b1111, 1, 32'h11, 4, 1, 32'h22, 5, 4'd2};
        vecs[5]  = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b1111, 1, 32'h33, 6, 1, 32'h44, 7, 4'd0};
        vecs[6]  = '{4'b1111, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0, 2'b00, 4'b1111, 0, 32'h0, 0,  0, 32'h0, 0,  4'd4};
        vecs[7]  = '{4'b0011, {32'h0, 32'h0, 32'hB2, 32'hB1},   1'b0, 2'b00, 4'b1111, 1, 32'hA1, 8, 1, 32'hA2, 9, 4'd6};
        vecs[8]  = '{4'b1111, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0, 2'b00, 4'b0011, 1, 32'hA1, 8, 1, 32'hA2, 9, 4'd8};
        vecs[9]  = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b0000, 1, 32'hA1, 8, 1, 32'hA2, 9, 4'd6};
        vecs[10] = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b0011, 1, 32'hA3, 10, 1, 32'hA4, 11, 4'd4};
        vecs[11] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'hD1},    1'b0, 2'b11, 4'b1111, 1, 32'hB1, 12, 1, 32'hB2, 13, 4'd3};
        vecs[12] = '{4'b0000, 128'h0,                           1'b0, 2'b11, 4'b1111, 1, 32'hC1, 14, 1, 32'hC2, 15, 4'd1};
        vecs[13] = '{4'b0000, 128'h0,                           1'b0, 2'b01, 4'b1111, 1, 32'hD1, 16, 0, 32'h0, 0,  4'd0};
        vecs[14] = '{4'b1110, {32'hE4, 32'hE3, 32'hE2, 32'h0},  1'b0, 2'b00, 4'b1111, 0, 32'h0, 0,  0, 32'h0, 0,  4'd0};
        vecs[15] = '{4'b0111, {32'h0, 32'hF3, 32'hF2, 32'hF1},  1'b0, 2'b00, 4'b1111, 0, 32'h0, 0,  0, 32'h0, 0,  4'd3};
        vecs[16] = '{4'b0000, 128'h0,                           1'b0, 2'b10, 4'b1111, 1, 32'hF1, 17, 1, 32'hF2, 18, 4'd3};
        vecs[17] = '{4'b0011, {32'h0, 32'h0, 32'h62, 32'h61},   1'b0, 2'b00, 4'b1111, 1, 32'hF1, 17, 1, 32'hF2, 18, 4'd5};
        vecs[18] = '{4'b1111, {32'h74, 32'h73, 32'h72, 32'h71}, 1'b1, 2'b11, 4'b0000, 1, 32'hF1, 17, 1, 32'hF2, 18, 4'd0};
        vecs[19] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h81},    1'b0, 2'b00, 4'b1111, 0, 32'h0, 0,  0, 32'h0, 0,  4'd1};
        vecs[20] = '{4'b0000, 128'h0,                           1'b0, 2'b01, 4'b1111, 1, 32'h81, 22, 0, 32'h0, 0,  4'd0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_occ", occupancy, 0);
        check("reset_iss0_valid", iss0_valid, 0);
        check("reset_iss1_valid", iss1_valid, 0);
        check("reset_allow", {d_al, c_al, b_al, a_al}, 4'b1111);
        @(negedge clk);
        rst = 1'b1;

        // table vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].d, vecs[i].fl, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_allow", i), {d_al, c_al, b_al, a_al}, vecs[i].e_allow);
            check($sformatf("v%0d_iss0_valid", i), iss0_valid, vecs[i].e_v0);
            check($sformatf("v%0d_iss1_valid", i), iss1_valid, vecs[i].e_v1);
            if (vecs[i].e_v0) begin
                check($sformatf("v%0d_iss0_data", i), iss0_data, vecs[i].e_d0);
                check($sformatf("v%0d_iss0_seq", i), iss0_seq, vecs[i].e_s0);
            end
            if (vecs[i].e_v1) begin
                check($sformatf("v%0d_iss1_data", i), iss1_data, vecs[i].e_d1);
                check($sformatf("v%0d_iss1_seq", i), iss1_seq, vecs[i].e_s1);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_occ", i), occupancy, vecs[i].e_occ);
        end

`ifdef IFU_DISPATCH_PERF_EN
        check("perf_full_stall_table", perf_full_stall, 2);
        check("perf_dual_issue_table", perf_dual_issue, 9);
`endif

        // 300 single-lane enqueue/issue pairs; sequence tag must wrap 255 -> 0
        model_seq = 8'd23;
        wrap_seen = 1'b0;
        prev_seq  = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(4'b0001, {96'h0, 32'h1000 + 32'(i)}, 1'b0, 2'b11);
            #1;
            check("wrap_allowA", a_al, 1);
            check("wrap_iss1_valid", iss1_valid, 0);
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                check("wrap_iss0_valid", iss0_valid, 1);
                check("wrap_iss0_entry", {iss0_seq, iss0_data}, item);
                if (prev_seq == 8'hFF && iss0_seq == 8'h00) wrap_seen = 1'b1;
                prev_seq = iss0_seq;
            end else begin
                check("wrap_iss0_empty", iss0_valid, 0);
            end
            exp_q.push_back({model_seq, 32'h1000 + 32'(i)});
            model_seq = model_seq + 8'd1;
            @(posedge clk);
        end
        @(negedge clk);
        drive(4'b0000, 128'h0, 1'b0, 2'b01);
        #1;
        item = exp_q.pop_front();
        check("wrap_last_entry", {iss0_seq, iss0_data}, item);
        @(posedge clk);
        #1;
        check("wrap_drained_occ", occupancy, 0);
        check("wrap_seen", wrap_seen, 1);
`ifdef IFU_DISPATCH_PERF_EN
        check("perf_dual_issue_wrap", perf_dual_issue, 9);
        check("perf_full_stall_wrap", perf_full_stall, 2);
`endif

        // asynchronous reset in the middle of operation
        @(negedge clk);
        drive(4'b0011, {64'h0, 32'h92, 32'h91}, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        check("pre_reset_occ", occupancy, 2);
        @(negedge clk);
        drive(4'b0000, 128'h0, 1'b0, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_occ", occupancy, 0);
        check("async_reset_iss0_valid", iss0_valid, 0);
        check("async_reset_allow", {d_al, c_al, b_al, a_al}, 4'b1111);
`ifdef IFU_DISPATCH_PERF_EN
        check("async_reset_perf_dual", perf_dual_issue, 0);
        check("async_reset_perf_stall", perf_full_stall, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0001, {96'h0, 32'hA5}, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        check("post_reset_occ", occupancy, 1);
        check("post_reset_seq", iss0_seq, 0);
        check("post_reset_data", iss0_data, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
